// File: rtl/axi_rd_arbiter_if.sv
// AXI read-channel bundle (AR and R) between the read arbiter and the AXI slave side.
// The arbiter uses the master modport; the slave modport is the view from the bus.
interface axi_rd_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between the I-cache and D-cache.
// One read is outstanding at a time; R beats are routed back to the granted cache.
module axi_rd_arbiter #(
    parameter int I_LEN = 7,
    parameter int D_LEN = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_rd_req,
    input  logic [31:0] i_rd_addr,
    input  logic [1:0]  i_rd_size,
    input  logic        i_burst,
    output logic        i_rd_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,

    input  logic        d_rd_req,
    input  logic [31:0] d_rd_addr,
    input  logic [1:0]  d_rd_size,
    input  logic        d_burst,
    output logic        d_rd_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,

    output logic [31:0] ret_data,
    input  logic        wr_idle,
    output logic        rd_busy,
    output logic        proto_err,

    axi_rd_arbiter_if.master axi
);

    localparam logic [7:0] L_I_LEN = 8'(I_LEN);
    localparam logic [7:0] L_D_LEN = 8'(D_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_grant;
    logic        r_last_grant;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;
    logic [1:0]  r_arburst;
    logic [7:0]  r_beat_cnt;
    logic        r_proto_err;

    logic        w_take;
    logic        w_grant_d;
    logic        w_sel_burst;
    logic [1:0]  w_sel_size;
    logic [31:0] w_sel_addr;
    logic        w_ar_done;
    logic        w_beat;
    logic        w_last_beat;
    logic        w_err_len;
    logic        w_err_id;
    logic        w_err_over;
    logic        w_arvalid;
    logic        w_rready;

    // Grant goes to the sole requester, or on a tie to whoever did not win last time.
    assign w_take      = (r_state == S_IDLE) && wr_idle && (i_rd_req || d_rd_req);
    assign w_grant_d   = d_rd_req && (!i_rd_req || !r_last_grant);
    assign w_sel_burst = w_grant_d ? d_burst   : i_burst;
    assign w_sel_size  = w_grant_d ? d_rd_size : i_rd_size;
    assign w_sel_addr  = w_grant_d ? d_rd_addr : i_rd_addr;

    assign w_ar_done   = (r_state == S_AR) && axi.arready;
    assign w_beat      = (r_state == S_R) && axi.rvalid;
    assign w_last_beat = w_beat && axi.rlast;

    assign w_err_len   = w_last_beat && (r_beat_cnt != r_arlen);
    assign w_err_id    = w_beat && (axi.rid != {3'b000, r_grant});
    assign w_err_over  = w_beat && !axi.rlast && (r_beat_cnt >= r_arlen);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_take)      w_next_state = S_AR;
            S_AR:    if (axi.arready) w_next_state = S_R;
            S_R:     if (w_last_beat) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake pulses and return routing are combinational so they line up with the bus beat.
    always_comb begin
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        rd_busy     = 1'b0;
        i_rd_rdy    = 1'b0;
        d_rd_rdy    = 1'b0;
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        d_ret_valid = 1'b0;
        d_ret_last  = 1'b0;
        unique case (r_state)
            S_AR: begin
                w_arvalid = 1'b1;
                rd_busy   = 1'b1;
                i_rd_rdy  = axi.arready && !r_grant;
                d_rd_rdy  = axi.arready &&  r_grant;
            end
            S_R: begin
                w_rready    = 1'b1;
                rd_busy     = 1'b1;
                i_ret_valid = axi.rvalid && !r_grant;
                i_ret_last  = axi.rvalid && axi.rlast && !r_grant;
                d_ret_valid = axi.rvalid &&  r_grant;
                d_ret_last  = axi.rvalid && axi.rlast &&  r_grant;
            end
            default: ;
        endcase
    end

    // AR fields are captured once at grant time so they cannot move while arvalid is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b0;
            r_araddr     <= 32'd0;
            r_arlen      <= 8'd0;
            r_arsize     <= 3'd0;
            r_arburst    <= 2'd0;
        end else if (w_take) begin
            r_grant      <= w_grant_d;
            r_last_grant <= w_grant_d;
            r_araddr     <= w_sel_addr;
            if (w_sel_burst) begin
                r_arlen   <= w_grant_d ? L_D_LEN : L_I_LEN;
                r_arsize  <= 3'b010;
                r_arburst <= 2'b01;
            end else begin
                r_arlen   <= 8'd0;
                r_arsize  <= {1'b0, w_sel_size};
                r_arburst <= 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_cnt <= 8'd0;
        end else if (w_ar_done) begin
            r_beat_cnt <= 8'd0;
        end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else if (w_err_len || w_err_id || w_err_over) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err   = r_proto_err;
    assign ret_data    = axi.rdata;

    assign axi.arid    = {3'b000, r_grant};
    assign axi.araddr  = r_araddr;
    assign axi.arlen   = r_arlen;
    assign axi.arsize  = r_arsize;
    assign axi.arburst = r_arburst;
    assign axi.arvalid = w_arvalid;
    assign axi.rready  = w_rready;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: table of grant/encoding vectors, hand-written corner sequences,
// and randomized traffic checked against a request-level round-robin model.
module tb_axi_rd_arbiter;

    localparam int I_LEN = 7;
    localparam int D_LEN = 3;

    logic        clk;
    logic        reset;
    logic        i_rd_req, d_rd_req;
    logic [31:0] i_rd_addr, d_rd_addr;
    logic [1:0]  i_rd_size, d_rd_size;
    logic        i_burst, d_burst;
    logic        i_rd_rdy, d_rd_rdy;
    logic        i_ret_valid, d_ret_valid;
    logic        i_ret_last, d_ret_last;
    logic [31:0] ret_data;
    logic        wr_idle;
    logic        rd_busy;
    logic        proto_err;

    int nCompared;
    int nMismatched;

    axi_rd_arbiter_if axi ();

    axi_rd_arbiter #(.I_LEN(I_LEN), .D_LEN(D_LEN)) dut (
        .clk(clk), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_size(i_rd_size), .i_burst(i_burst),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_size(d_rd_size), .d_burst(d_burst),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .ret_data(ret_data), .wr_idle(wr_idle), .rd_busy(rd_busy), .proto_err(proto_err),
        .axi(axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to end earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        iReq;
        logic        dReq;
        logic        iBurst;
        logic        dBurst;
        logic [1:0]  iSize;
        logic [1:0]  dSize;
        logic [31:0] iAddr;
        logic [31:0] dAddr;
        logic        expD;
        logic [31:0] expAddr;
        logic [7:0]  expLen;
        logic [2:0]  expSize;
        logic [1:0]  expBurst;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic iReq, input logic iBurst, input logic [1:0] iSize,
                                 input logic [31:0] iAddr, input logic dReq, input logic dBurst,
                                 input logic [1:0] dSize, input logic [31:0] dAddr);
        i_rd_req  = iReq;  i_burst = iBurst; i_rd_size = iSize; i_rd_addr = iAddr;
        d_rd_req  = dReq;  d_burst = dBurst; d_rd_size = dSize; d_rd_addr = dAddr;
    endtask

    // Encoding rule for a granted request, written from the bus-level description.
    function automatic void expectedAr(input logic isD, input logic burst, input logic [1:0] size,
                                       output logic [7:0] len, output logic [2:0] sz, output logic [1:0] bt);
        if (burst) begin
            len = isD ? 8'(D_LEN) : 8'(I_LEN);
            sz  = 3'd2;
            bt  = 2'd1;
        end else begin
            len = 8'd0;
            sz  = {1'b0, size};
            bt  = 2'd0;
        end
    endfunction

    // Entered in the IDLE cycle whose closing edge takes the grant; returns in the following IDLE cycle.
    task automatic runTxn(input logic expD, input logic [31:0] expAddr, input logic [7:0] expLen,
                          input logic [2:0] expSize, input logic [1:0] expBurst, input int arDelay,
                          input int gapMax, input logic dropOther, input logic jitter);
        logic [31:0] data;
        int gap;
        @(negedge clk);
        checkOutput("idle_arvalid", axi.arvalid, 1'b0);
        checkOutput("idle_busy", rd_busy, 1'b0);
        checkOutput("idle_proto_err", proto_err, 1'b0);
        tick();
        for (int c = 0; c <= arDelay; c++) begin
            axi.arready = (c == arDelay);
            axi.rvalid  = jitter ? 1'($urandom % 2) : 1'b0;
            if (jitter) wr_idle = 1'($urandom % 2);
            @(negedge clk);
            checkOutput("ar_arvalid", axi.arvalid, 1'b1);
            checkOutput("ar_busy", rd_busy, 1'b1);
            checkOutput("ar_rready", axi.rready, 1'b0);
            checkOutput("ar_arid", axi.arid, {3'b000, expD});
            checkOutput("ar_araddr", axi.araddr, expAddr);
            checkOutput("ar_arlen", axi.arlen, expLen);
            checkOutput("ar_arsize", axi.arsize, expSize);
            checkOutput("ar_arburst", axi.arburst, expBurst);
            checkOutput("ar_i_rd_rdy", i_rd_rdy, (c == arDelay) && !expD);
            checkOutput("ar_d_rd_rdy", d_rd_rdy, (c == arDelay) && expD);
            checkOutput("ar_no_route", i_ret_valid | d_ret_valid, 1'b0);
            tick();
        end
        axi.arready = 1'b0;
        if (expD) d_rd_req = 1'b0;
        else      i_rd_req = 1'b0;
        if (dropOther) begin
            i_rd_req = 1'b0;
            d_rd_req = 1'b0;
        end
        for (int b = 0; b <= int'(expLen); b++) begin
            gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                axi.rvalid = 1'b0;
                @(negedge clk);
                checkOutput("gap_rready", axi.rready, 1'b1);
                checkOutput("gap_ret_valid", i_ret_valid | d_ret_valid, 1'b0);
                tick();
            end
            data = $urandom;
            axi.rvalid = 1'b1;
            axi.rid    = {3'b000, expD};
            axi.rlast  = (b == int'(expLen));
            axi.rdata  = data;
            if (jitter) wr_idle = 1'($urandom % 2);
            @(negedge clk);
            checkOutput("r_rready", axi.rready, 1'b1);
            checkOutput("r_i_ret_valid", i_ret_valid, !expD);
            checkOutput("r_d_ret_valid", d_ret_valid, expD);
            checkOutput("r_i_ret_last", i_ret_last, !expD && (b == int'(expLen)));
            checkOutput("r_d_ret_last", d_ret_last, expD && (b == int'(expLen)));
            checkOutput("r_ret_data", ret_data, data);
            checkOutput("r_proto_err", proto_err, 1'b0);
            tick();
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        wr_idle    = 1'b1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("rst_arvalid", axi.arvalid, 1'b0);
        checkOutput("rst_rready", axi.rready, 1'b0);
        checkOutput("rst_busy", rd_busy, 1'b0);
        checkOutput("rst_proto_err", proto_err, 1'b0);
        checkOutput("rst_rdy", {i_rd_rdy, d_rd_rdy}, 2'b00);
        checkOutput("rst_ret", {i_ret_valid, i_ret_last, d_ret_valid, d_ret_last}, 4'b0000);
        checkOutput("rst_ar_regs", {axi.arid, axi.arlen, axi.arsize, axi.arburst}, 17'd0);
        checkOutput("rst_araddr", axi.araddr, 32'd0);
        tick();
        reset = 1'b0;
    endtask

    logic        pend   [2];
    logic [31:0] pAddr  [2];
    logic [1:0]  pSize  [2];
    logic        pBurst [2];
    logic        lastD;

    initial begin
        logic [7:0] eLen;
        logic [2:0] eSize;
        logic [1:0] eBurst;
        logic       winD;

        nCompared   = 0;
        nMismatched = 0;
        reset = 1'b1;
        wr_idle = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rlast   = 1'b1;
        axi.rid     = 4'd0;
        axi.rdata   = 32'h0;

        applyReset();
        @(negedge clk);
        checkOutput("idle_ignore_rvalid", i_ret_valid | d_ret_valid, 1'b0);
        tick();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h1fc0_0000, 32'h0,
                    1'b0, 32'h1fc0_0000, 8'd7, 3'd2, 2'd1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 32'h1fc0_0020, 32'h8000_1000,
                    1'b1, 32'h8000_1000, 8'd3, 3'd2, 2'd1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 32'h1fc0_0004, 32'h8000_2000,
                    1'b0, 32'h1fc0_0004, 8'd0, 3'd1, 2'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 32'h0, 32'hbfaf_8000,
                    1'b1, 32'hbfaf_8000, 8'd0, 3'd1, 2'd0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 32'h1fc0_0040, 32'hbfaf_8004,
                    1'b0, 32'h1fc0_0040, 8'd7, 3'd2, 2'd1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 32'h1fc0_0013, 32'hbfaf_8013,
                    1'b1, 32'hbfaf_8013, 8'd0, 3'd0, 2'd0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0, 32'h0000_0040,
                    1'b1, 32'h0000_0040, 8'd3, 3'd2, 2'd1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 32'h1fc0_0100, 32'h0000_0080,
                    1'b0, 32'h1fc0_0100, 8'd0, 3'd2, 2'd0};

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].iReq, vecs[v].iBurst, vecs[v].iSize, vecs[v].iAddr,
                          vecs[v].dReq, vecs[v].dBurst, vecs[v].dSize, vecs[v].dAddr);
            runTxn(vecs[v].expD, vecs[v].expAddr, vecs[v].expLen, vecs[v].expSize,
                   vecs[v].expBurst, 0, 0, 1'b1, 1'b0);
        end

        $display("[TB] arready stall");
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h1fc0_0000, 1'b0, 1'b0, 2'd0, 32'd0);
        runTxn(1'b0, 32'h1fc0_0000, 8'd7, 3'd2, 2'd1, 5, 0, 1'b1, 1'b0);

        $display("[TB] write path busy");
        wr_idle = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 2'd2, 32'h0000_0100);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("wr_busy_arvalid", axi.arvalid, 1'b0);
            tick();
        end
        wr_idle = 1'b1;
        runTxn(1'b1, 32'h0000_0100, 8'd0, 3'd2, 2'd0, 0, 0, 1'b1, 1'b0);

        $display("[TB] simultaneous pairs after reset");
        applyReset();
        for (int p = 0; p < 2; p++) begin
            applyStimulus(1'b1, 1'b1, 2'd0, 32'h1fc0_1000, 1'b1, 1'b1, 2'd0, 32'h8000_3000);
            runTxn(1'b1, 32'h8000_3000, 8'd3, 3'd2, 2'd1, 0, 0, 1'b0, 1'b0);
            runTxn(1'b0, 32'h1fc0_1000, 8'd7, 3'd2, 2'd1, 0, 0, 1'b0, 1'b0);
        end

        $display("[TB] randomized traffic");
        lastD = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom % 2 == 0)) begin
                    pend[p] = 1'b1; pAddr[p] = $urandom; pSize[p] = 2'($urandom); pBurst[p] = 1'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[it % 2] = 1'b1; pAddr[it % 2] = $urandom; pSize[it % 2] = 2'($urandom);
                pBurst[it % 2] = 1'($urandom);
            end
            applyStimulus(pend[0], pBurst[0], pSize[0], pAddr[0], pend[1], pBurst[1], pSize[1], pAddr[1]);
            wr_idle = 1'b0;
            for (int h = 0; h < int'($urandom % 3); h++) begin
                @(negedge clk);
                checkOutput("rnd_hold_arvalid", axi.arvalid, 1'b0);
                tick();
            end
            wr_idle = 1'b1;
            winD = (pend[0] && pend[1]) ? !lastD : pend[1];
            expectedAr(winD, pBurst[winD], pSize[winD], eLen, eSize, eBurst);
            runTxn(winD, pAddr[winD], eLen, eSize, eBurst, int'($urandom % 4), 2, 1'b0, 1'b1);
            pend[winD] = 1'b0;
            lastD = winD;
        end
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;

        $display("[TB] protocol error on single read");
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 2'd1, 32'hbfaf_8000);
        @(negedge clk);
        checkOutput("perr_idle_proto_err", proto_err, 1'b0);
        tick();
        axi.arready = 1'b1;
        @(negedge clk);
        checkOutput("perr_arlen", axi.arlen, 8'd0);
        checkOutput("perr_d_rd_rdy", d_rd_rdy, 1'b1);
        tick();
        axi.arready = 1'b0;
        d_rd_req = 1'b0;
        axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rlast = 1'b0; axi.rdata = 32'h1234_5678;
        @(negedge clk);
        checkOutput("perr_beat1_valid", d_ret_valid, 1'b1);
        checkOutput("perr_beat1_before", proto_err, 1'b0);
        tick();
        axi.rlast = 1'b1;
        @(negedge clk);
        checkOutput("perr_beat1_after", proto_err, 1'b1);
        checkOutput("perr_beat2_last", d_ret_last, 1'b1);
        tick();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        @(negedge clk);
        checkOutput("perr_back_idle", rd_busy, 1'b0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("perr_sticky", proto_err, 1'b1);
        tick();

        $display("[TB] reset during R");
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 2'd0, 32'h0000_0200);
        tick();
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        d_rd_req = 1'b0;
        axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rlast = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstr_beat2_valid", d_ret_valid, 1'b1);
        tick();
        reset = 1'b0;
        axi.rvalid = 1'b0;
        @(negedge clk);
        checkOutput("rstr_arvalid", axi.arvalid, 1'b0);
        checkOutput("rstr_rready", axi.rready, 1'b0);
        checkOutput("rstr_busy", rd_busy, 1'b0);
        checkOutput("rstr_proto_err", proto_err, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 2'd2, 32'h0000_0300);
        runTxn(1'b1, 32'h0000_0300, 8'd0, 3'd2, 2'd0, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("final_proto_err", proto_err, 1'b0);
        checkOutput("final_busy", rd_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Round-robin scheduler that shares the single AXI read channel (AR/R) between the instruction-cache and data-cache refill/uncached-read ports. It sits between the two `cache` instances and the AXI master interface, replacing the combinational fixed-priority AR selection. It provides:
- registered, AXI-stable AR outputs;
- one outstanding read at a time, held until `rlast`;
- per-requester routing of R beats, with a beat counter and protocol checking;
- a busy flag that the write path uses to order reads against writes.

## Interface
Parameters:
- I_LEN, 7, arlen for I-cache line bursts (beats-1)
- D_LEN, 3, arlen for D-cache line bursts (beats-1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_rd_req  in  1  I-cache read request; held until i_rd_rdy
- i_rd_addr  in  32  I-cache read address
- i_rd_size  in  2  I-cache size for single-beat reads
- i_burst  in  1  1 = line burst, 0 = single beat
- i_rd_rdy  out  1  AR handshake done for I request
- i_ret_valid  out  1  R beat valid for I-cache
- i_ret_last  out  1  last beat for I-cache
- d_rd_req, d_rd_addr, d_rd_size, d_burst, d_rd_rdy, d_ret_valid, d_ret_last  (same as I, for D-cache)
- ret_data  out  32  rdata pass-through
- wr_idle  in  1  write channel idle; arbitration only when 1
- rd_busy  out  1  state != IDLE
- proto_err  out  1  sticky R protocol error
- arid  out  4  0 = I, 1 = D
- araddr  out  32
- arlen  out  8
- arsize  out  3
- arburst  out  2
- arvalid  out  1
- arready  in  1
- rid  in  4
- rdata  in  32
- rlast  in  1
- rvalid  in  1
- rready  out  1

## Operation
- FSM has three states: IDLE, AR, R.
- **IDLE:**
  - Arbitration happens only if wr_idle=1 and at least one request is high.
  - If only one requester is asserting, it wins.
  - If both are asserting, the winner is the one not recorded in last_grant.
  - On a grant:
    - latch grant, addr, size and burst into AR registers;
    - update last_grant;
    - go to AR.
- **AR-register encoding:**
  - burst: arsize=3'b010, arburst=INCR (2'b01), arlen=I_LEN or D_LEN.
  - single: arsize={1'b0,size}, arburst=FIXED (2'b00), arlen=0.
  - araddr = latched address; arid = 0 for I, 1 for D.
- **AR:**
  - arvalid=1; all ar* outputs stay stable until arready.
  - On arready, pulse the granted port's x_rd_rdy combinationally in the same cycle, clear the beat counter, and go to R.
- **R:**
  - rready=1.
  - Route rvalid/rlast to the granted port's x_ret_valid/x_ret_last; the other port sees 0.
  - Each rvalid increments the 8-bit beat counter.
  - On rvalid & rlast, go to IDLE.
- **proto_err** is set (sticky until reset) when:
  - rlast arrives with counter != arlen;
  - rvalid arrives with rid != arid;
  - counter would exceed arlen without rlast.
- ret_data = rdata at all times.
- Outside R, rready=0 and rvalid is ignored (no routing, no counting).
- Requesters must hold x_rd_req/addr/size/burst until x_rd_rdy. A grant is committed once taken; a dropped request is not cancelled.

## Timing
- Reset values: state=IDLE, last_grant=I (first tie goes to D), arvalid=0, rready=0, proto_err=0, counter=0, rd_busy=0, all x_rd_rdy/x_ret_* = 0, ar* registers = 0.
- Request seen in IDLE at cycle 0 → arvalid=1 at cycle 1.
- Earliest x_rd_rdy is cycle 1 (arready=1 at cycle 1).
- The first R beat can be accepted at cycle 2.
- The rlast beat is at cycle N → state=IDLE at N+1 → next arvalid at N+2.
- Minimum AR-to-AR spacing is therefore 2 cycles after rlast.
- If wr_idle drops in AR or R, the current transaction continues; only new grants are blocked.
- A request arriving while the other port is in AR or R waits in IDLE; round-robin guarantees it is served next.
- Reset mid-transaction returns to IDLE in the next cycle with arvalid=0 and drops any in-flight beats. Reset of the AXI slave is the system's responsibility.

## Test plan
- Single I burst: i_rd_req, i_burst=1, addr 0x1fc0_0000, arready at cycle 1, 8 beats with rlast on the 8th → arlen=7, arsize=2, arburst=1, arid=0, i_rd_rdy pulses once, i_ret_valid ×8, proto_err=0.
- Simultaneous i/d requests after reset → D granted first (arid=1, arlen=3), then I granted 2 cycles after D's rlast. A second simultaneous pair alternates the order again.
- arready stalled 5 cycles → ar* stable all 6 cycles, x_rd_rdy asserted only in the arready cycle.
- wr_idle=0 with d_rd_req pending 10 cycles → arvalid stays 0; wr_idle=1 → arvalid next cycle.
- D uncached read, size=1, addr 0xbfaf_8000 → arlen=0, arsize=1, arburst=0; rlast on the 1st beat gives proto_err=0. A second run with rlast on the 2nd beat gives proto_err=1 and it stays 1.
- Reset asserted mid-R (beat 2 of 4) → next cycle IDLE, arvalid=0, rready=0, counter=0.
